// File: rtl/hdlc_tx_sequencer.sv
// Loads source frames into the HDLC core TX buffer over its register port,
// starts transmission, polls Tx_SC for Done and handles abort requests.
module hdlc_tx_sequencer #(
  parameter logic [2:0] ADDR_TX_SC   = 3'h0,
  parameter logic [2:0] ADDR_TX_BUFF = 3'h1,
  parameter int         MAX_BYTES    = 126,
  parameter int         POLL_GAP     = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       src_valid,
  input  logic [7:0] src_data,
  input  logic       src_last,
  output logic       src_ready,
  input  logic       abort_req,
  output logic [2:0] Address,
  output logic       WriteEnable,
  output logic       ReadEnable,
  output logic [7:0] DataIn,
  input  logic [7:0] DataOut,
  output logic       busy,
  output logic       frame_sent,
  output logic       frame_aborted,
  output logic       len_err
);

  localparam int CW = $clog2(MAX_BYTES + 1);
  localparam int TW = $clog2(POLL_GAP + 1);

  typedef enum logic [2:0] {
    IDLE, PRECHK, LOAD, DRAIN, START, POLL, ABORT, ABWAIT
  } state_t;

  state_t        state, nState;
  logic [CW-1:0] count, nCount;
  logic [TW-1:0] timer, nTimer;
  logic          sample;
  logic          abortPend, nAbortPend;
  logic          nWe, nRe, nSent, nAborted, nLenErr;
  logic [2:0]    nAddr;
  logic [7:0]    nData;
  logic          accept;
  logic          pollStep;
  logic [6:0]    unusedBits;

  assign accept     = src_valid && src_ready;
  assign unusedBits = DataOut[7:1];

  always_comb begin
    nState     = state;
    nCount     = count;
    nTimer     = timer;
    nAbortPend = abortPend;
    nWe        = 1'b0;
    nRe        = 1'b0;
    nAddr      = Address;
    nData      = DataIn;
    nSent      = 1'b0;
    nAborted   = 1'b0;
    nLenErr    = 1'b0;
    pollStep   = 1'b0;
    unique case (state)
      IDLE: begin
        nTimer = '0;
        if (src_valid) nState = PRECHK;
      end
      PRECHK: begin
        if (abort_req) begin
          nState = IDLE;
        end else if (sample && DataOut[0]) begin
          nState = LOAD;
          nCount = '0;
        end else begin
          pollStep = 1'b1;
        end
      end
      LOAD: begin
        if (accept) begin
          nWe    = 1'b1;
          nAddr  = ADDR_TX_BUFF;
          nData  = src_data;
          nCount = count + CW'(1);
        end
        if (abort_req) begin
          nState = ABORT;
        end else if (accept && src_last) begin
          nState = START;
        end else if (accept && count == CW'(MAX_BYTES - 1)) begin
          nLenErr = 1'b1;
          nState  = DRAIN;
        end
      end
      DRAIN: begin
        if (abort_req) nState = ABORT;
        else if (accept && src_last) nState = START;
      end
      START: begin
        nWe    = 1'b1;
        nAddr  = ADDR_TX_SC;
        nData  = 8'h02;
        nTimer = '0;
        nState = abort_req ? ABORT : POLL;
      end
      POLL: begin
        // a read already on the bus must return its data before aborting
        if (abort_req || abortPend) begin
          if (ReadEnable) begin
            nAbortPend = 1'b1;
          end else begin
            nAbortPend = 1'b0;
            nState     = ABORT;
          end
        end else if (sample && DataOut[0]) begin
          nSent  = 1'b1;
          nCount = '0;
          nState = IDLE;
        end else begin
          pollStep = 1'b1;
        end
      end
      ABORT: begin
        nWe    = 1'b1;
        nAddr  = ADDR_TX_SC;
        nData  = 8'h04;
        nTimer = '0;
        nState = ABWAIT;
      end
      ABWAIT: begin
        if (sample && DataOut[0]) begin
          nAborted = 1'b1;
          nCount   = '0;
          nState   = IDLE;
        end else begin
          pollStep = 1'b1;
        end
      end
    endcase
    // read, one data cycle, then POLL_GAP idle cycles before the next read
    if (pollStep && !ReadEnable) begin
      if (sample) begin
        nTimer = TW'(POLL_GAP - 1);
      end else if (timer == '0) begin
        nRe   = 1'b1;
        nAddr = ADDR_TX_SC;
      end else begin
        nTimer = timer - TW'(1);
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state         <= IDLE;
      count         <= '0;
      timer         <= '0;
      sample        <= 1'b0;
      abortPend     <= 1'b0;
      src_ready     <= 1'b0;
      Address       <= '0;
      WriteEnable   <= 1'b0;
      ReadEnable    <= 1'b0;
      DataIn        <= '0;
      busy          <= 1'b0;
      frame_sent    <= 1'b0;
      frame_aborted <= 1'b0;
      len_err       <= 1'b0;
    end else begin
      state         <= nState;
      count         <= nCount;
      timer         <= nTimer;
      sample        <= ReadEnable;
      abortPend     <= nAbortPend;
      src_ready     <= (nState == LOAD) || (nState == DRAIN);
      Address       <= nAddr;
      WriteEnable   <= nWe;
      ReadEnable    <= nRe;
      DataIn        <= nData;
      busy          <= (nState != IDLE);
      frame_sent    <= nSent;
      frame_aborted <= nAborted;
      len_err       <= nLenErr;
    end
  end

endmodule
